// File: rtl/fastinput_frame_sequencer_if.sv
// Signal bundle between the fast-input frame sequencer and the UART RX/TX, the
// channel counters and the status consumers around it.
interface fastinput_frame_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic [7:0]            rx_data;
    logic                  rx_done;
    logic [32*NUM_CH-1:0]  ch_data;
    logic                  tx_done;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  clr_req;
    logic                  busy;
    logic                  frame_done;
    logic                  timeout_err;

    // master is the sequencer; slave is the surrounding RX/TX/counter logic
    modport master (
        input  rx_data, rx_done, ch_data, tx_done,
        output tx_start, tx_data, clr_req, busy, frame_done, timeout_err
    );

    modport slave (
        output rx_data, rx_done, ch_data, tx_done,
        input  tx_start, tx_data, clr_req, busy, frame_done, timeout_err
    );
endinterface

// File: rtl/fastinput_frame_sequencer.sv
// Request-driven response framer: snapshots all channel counters on a read command and
// walks the frame one byte at a time through the UART transmitter's start/done handshake.
module fastinput_frame_sequencer #(
    parameter int         NUM_CH       = 4,
    parameter logic [7:0] HDR_BYTE     = 8'h06,
    parameter logic [7:0] CMD_READ     = 8'h05,
    parameter logic [7:0] CMD_READ_CLR = 8'h0A,
    parameter int         TIMEOUT_CYC  = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    fastinput_frame_sequencer_if.master bus
);
    localparam int FRAME_LEN = 4 * NUM_CH + 3;
    localparam int IW        = $clog2(FRAME_LEN);
    localparam int TW        = $clog2(TIMEOUT_CYC);

    localparam logic [IW-1:0] IDX_LAST   = IW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [31:0]   snap_reg [NUM_CH];
    logic [15:0]   csum_reg, csum_next;
    logic [7:0]    tx_data_reg;
    logic          clr_req_reg, clr_req_next;
    logic          frame_done_reg, frame_done_next;
    logic          timeout_err_reg, timeout_err_next;
    logic          req_valid;
    logic          accept;
    logic          load_byte;
    logic [7:0]    frame_byte [FRAME_LEN];

    assign req_valid = bus.rx_done &&
                       ((bus.rx_data == CMD_READ) || (bus.rx_data == CMD_READ_CLR));

    // The frame_done cycle already reads as idle, but a request landing there is dropped.
    assign accept = (state_reg == ST_IDLE) && req_valid && !frame_done_reg;

    // Only the low 16 bits of the 32-bit channel sum are transmitted, so the
    // low halves alone are enough.
    always_comb begin
        csum_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            csum_next = csum_next + snap_reg[i][15:0];
        end
    end

    assign frame_byte[0]           = HDR_BYTE;
    assign frame_byte[FRAME_LEN-2] = csum_reg[7:0];
    assign frame_byte[FRAME_LEN-1] = csum_reg[15:8];

    genvar gi, gb;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            for (gb = 0; gb < 4; gb++) begin : g_byte
                assign frame_byte[1 + 4*gi + gb] = snap_reg[gi][8*gb +: 8];
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        timer_next       = timer_reg;
        load_byte        = 1'b0;
        clr_req_next     = 1'b0;
        frame_done_next  = 1'b0;
        timeout_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_LOAD;
                    idx_next     = '0;
                    timer_next   = '0;
                    load_byte    = 1'b1;
                    clr_req_next = (bus.rx_data == CMD_READ_CLR);
                end
            end
            ST_LOAD: begin
                state_next = ST_WAIT;
                timer_next = timer_reg + 1'b1;
            end
            ST_WAIT: begin
                timer_next = timer_reg + 1'b1;
                // tx_done takes priority over a timeout expiring in the same cycle
                if (bus.tx_done) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next      = ST_IDLE;
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = ST_LOAD;
                        idx_next   = idx_reg + 1'b1;
                        timer_next = '0;
                        load_byte  = 1'b1;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next       = ST_IDLE;
                    timeout_err_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // timer_reg counts cycles since the byte's tx_start, so the terminal WAIT
    // cycle is TIMEOUT_CYC-1 cycles after it and timeout_err lands at TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            timer_reg       <= '0;
            csum_reg        <= '0;
            tx_data_reg     <= '0;
            clr_req_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            timer_reg       <= timer_next;
            csum_reg        <= csum_next;
            clr_req_reg     <= clr_req_next;
            frame_done_reg  <= frame_done_next;
            timeout_err_reg <= timeout_err_next;
            if (load_byte) begin
                tx_data_reg <= frame_byte[idx_next];
            end
            if (accept) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    snap_reg[i] <= bus.ch_data[32*i +: 32];
                end
            end
        end
    end

    assign bus.tx_start    = (state_reg == ST_LOAD);
    assign bus.tx_data     = tx_data_reg;
    assign bus.clr_req     = clr_req_reg;
    assign bus.busy        = (state_reg != ST_IDLE);
    assign bus.frame_done  = frame_done_reg;
    assign bus.timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_fastinput_frame_sequencer.sv
// Directed bench for the frame sequencer: a transaction-level frame model checked every
// cycle, a timed transmitter responder, and hand-computed literal expectations per scenario.
module tb_fastinput_frame_sequencer;
    localparam int NCH    = 4;
    localparam int TMO    = 100;
    localparam int FLEN   = 4 * NCH + 3;
    localparam logic [7:0] CMD_RD = 8'h05;
    localparam logic [7:0] CMD_RC = 8'h0A;

    logic clk = 1'b0;
    logic rst;

    fastinput_frame_sequencer_if #(.NUM_CH(NCH)) sif ();

    fastinput_frame_sequencer #(
        .NUM_CH      (NCH),
        .HDR_BYTE    (8'h06),
        .CMD_READ    (CMD_RD),
        .CMD_READ_CLR(CMD_RC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // responder configuration (written by the stimulus, read by the responder)
    int   resp_delay   = 10;
    int   withhold_idx = -1;
    int   slow_idx     = -1;
    int   slow_delay   = 10;
    logic inject_done  = 1'b0;

    // expected-output model state
    logic [7:0] m_frame [FLEN];
    bit         in_frame = 0;
    int         pos = 0;
    int         start_cyc = 0;
    logic       m_start = 0, m_fd = 0, m_to = 0, m_clr = 0, m_busy = 0;
    logic [7:0] m_data = 8'h00;

    // observations of the DUT
    logic [7:0] cap_bytes [$];
    int         cap_cyc [$];
    int         obs_fd = 0, obs_to = 0, obs_clr = 0;
    int         last_to_cyc = 0, last_clr_cyc = 0;
    logic       busy_at_to = 1'b1;

    logic [7:0] exp1 [FLEN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame as the protocol defines it: header, channels little-endian, low 16 bits of the sum.
    task automatic build_frame(input logic [32*NCH-1:0] ch);
        logic [31:0] sum;
        sum = 32'h0;
        m_frame[0] = 8'h06;
        for (int k = 0; k < NCH; k++) begin
            sum = sum + ch[32*k +: 32];
            for (int b = 0; b < 4; b++) begin
                m_frame[1 + 4*k + b] = ch[32*k + 8*b +: 8];
            end
        end
        m_frame[FLEN-2] = sum[7:0];
        m_frame[FLEN-1] = sum[15:8];
    endtask

    task automatic model_step();
        bit fd_this;
        if (sif.tx_start === 1'b1) begin
            cap_bytes.push_back(sif.tx_data);
            cap_cyc.push_back(cyc);
        end
        if (sif.frame_done === 1'b1) obs_fd++;
        if (sif.timeout_err === 1'b1) begin
            obs_to++;
            last_to_cyc = cyc;
            busy_at_to  = sif.busy;
        end
        if (sif.clr_req === 1'b1) begin
            obs_clr++;
            last_clr_cyc = cyc;
        end

        check("tx_start",    sif.tx_start,    m_start);
        check("frame_done",  sif.frame_done,  m_fd);
        check("timeout_err", sif.timeout_err, m_to);
        check("clr_req",     sif.clr_req,     m_clr);
        check("busy",        sif.busy,        m_busy);
        check("tx_data",     sif.tx_data,     m_data);

        fd_this = m_fd;
        m_start = 0; m_fd = 0; m_to = 0; m_clr = 0;
        if (rst) begin
            in_frame = 0;
            m_busy   = 0;
            m_data   = 8'h00;
        end else if (!in_frame) begin
            if (sif.rx_done && (sif.rx_data == CMD_RD || sif.rx_data == CMD_RC) && !fd_this) begin
                build_frame(sif.ch_data);
                pos       = 0;
                in_frame  = 1;
                start_cyc = cyc + 1;
                m_start   = 1;
                m_data    = m_frame[0];
                m_busy    = 1;
                m_clr     = (sif.rx_data == CMD_RC);
            end
        end else if (cyc > start_cyc) begin
            if (sif.tx_done) begin
                if (pos == FLEN - 1) begin
                    in_frame = 0;
                    m_busy   = 0;
                    m_fd     = 1;
                end else begin
                    pos++;
                    start_cyc = cyc + 1;
                    m_start   = 1;
                    m_data    = m_frame[pos];
                end
            end else if (cyc - start_cyc == TMO - 1) begin
                in_frame = 0;
                m_busy   = 0;
                m_to     = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_rx(input logic [7:0] b);
        sif.rx_data = b;
        sif.rx_done = 1'b1;
        tick();
        sif.rx_done = 1'b0;
    endtask

    task automatic wait_end(input int bound, input bit scramble);
        int e0;
        e0 = obs_fd + obs_to;
        for (int i = 0; i < bound && (obs_fd + obs_to) == e0; i++) begin
            if (scramble) sif.ch_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        check("frame_end", obs_fd + obs_to - e0, 1);
    endtask

    task automatic wait_bytes(input int n, input int bound);
        for (int i = 0; i < bound && cap_bytes.size() < n; i++) tick();
        check("byte_reached", (cap_bytes.size() >= n) ? 1 : 0, 1);
    endtask

    // Transmitter model: tx_done a configurable number of cycles after each tx_start.
    initial begin : responder
        int   cnt;
        int   bno;
        logic prev_busy;
        cnt = -1;
        bno = 0;
        prev_busy = 1'b0;
        sif.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sif.tx_done = inject_done;
            if (sif.busy !== 1'b1) cnt = -1;
            if (sif.tx_start === 1'b1) begin
                bno = prev_busy ? bno + 1 : 0;
                if (bno == withhold_idx) cnt = -1;
                else if (bno == slow_idx) cnt = slow_delay;
                else cnt = resp_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    sif.tx_done = 1'b1;
                    cnt = -1;
                end
            end
            prev_busy = (sif.busy === 1'b1);
        end
    end

    initial begin : stimulus
        int b0, fd0, to0, clr0, rx_cyc;
        exp1 = '{8'h06, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h44, 8'h33};
        rst = 1'b1;
        sif.rx_data = 8'h00;
        sif.rx_done = 1'b0;
        sif.ch_data = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy",     sif.busy,     0);
        check("reset_tx_start", sif.tx_start, 0);
        check("reset_tx_data",  sif.tx_data,  0);
        repeat (2) tick();

        // basic read
        sif.ch_data = {32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h11223344};
        b0 = cap_bytes.size(); fd0 = obs_fd; clr0 = obs_clr; rx_cyc = cyc;
        send_rx(CMD_RD);
        wait_end(400, 0);
        check("t1_nbytes", cap_bytes.size() - b0, FLEN);
        if (cap_bytes.size() >= b0 + FLEN) begin
            for (int i = 0; i < FLEN; i++) check($sformatf("t1_byte%0d", i), cap_bytes[b0+i], exp1[i]);
            check("t1_latency", cap_cyc[b0] - rx_cyc, 1);
            check("t1_byte_period", cap_cyc[b0+1] - cap_cyc[b0], 11);
        end
        check("t1_frame_done", obs_fd - fd0, 1);
        check("t1_clr_req", obs_clr - clr0, 0);
        repeat (3) tick();

        // snapshot integrity with channels changing every cycle
        sif.ch_data = {32'h80000001, 32'h80000000, 32'h0A0B0C0D, 32'h01020304};
        b0 = cap_bytes.size();
        send_rx(CMD_RD);
        wait_end(400, 1);
        check("t2_nbytes", cap_bytes.size() - b0, FLEN);
        if (cap_bytes.size() >= b0 + FLEN) begin
            check("t2_ch0_lsb", cap_bytes[b0+1],  8'h04);
            check("t2_ch1_lsb", cap_bytes[b0+5],  8'h0D);
            check("t2_ch3_msb", cap_bytes[b0+16], 8'h80);
            check("t2_csum_lo", cap_bytes[b0+17], 8'h12);
            check("t2_csum_hi", cap_bytes[b0+18], 8'h0F);
        end
        repeat (3) tick();

        // read-and-clear; counters drop to zero right after the request
        sif.ch_data = {32'h00000040, 32'h00000030, 32'h00000020, 32'h00000010};
        b0 = cap_bytes.size(); clr0 = obs_clr; rx_cyc = cyc;
        send_rx(CMD_RC);
        sif.ch_data = '0;
        wait_end(400, 0);
        check("t3_clr_count", obs_clr - clr0, 1);
        check("t3_clr_cycle", last_clr_cyc - rx_cyc, 1);
        if (cap_bytes.size() >= b0 + FLEN) begin
            check("t3_ch0_lsb", cap_bytes[b0+1],  8'h10);
            check("t3_csum_lo", cap_bytes[b0+17], 8'hA0);
            check("t3_csum_hi", cap_bytes[b0+18], 8'h00);
        end
        repeat (3) tick();

        // requests while busy and in the frame_done cycle are dropped
        sif.ch_data = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};
        b0 = cap_bytes.size(); fd0 = obs_fd;
        send_rx(CMD_RD);
        wait_bytes(b0 + 6, 100);
        send_rx(CMD_RD);
        for (int i = 0; i < 400 && !m_fd; i++) tick();
        check("t4_fd_cycle", sif.frame_done, 1);
        send_rx(CMD_RD);
        send_rx(CMD_RD);
        check("t4_restart_start", sif.tx_start, 1);
        check("t4_restart_hdr", sif.tx_data, 8'h06);
        wait_end(400, 0);
        check("t4_frames", obs_fd - fd0, 2);
        check("t4_nbytes", cap_bytes.size() - b0, 2 * FLEN);
        b0 = cap_bytes.size();
        send_rx(8'h33);
        repeat (5) tick();
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        repeat (3) tick();
        check("t4_unknown_busy", sif.busy, 0);
        check("t4_unknown_nbytes", cap_bytes.size() - b0, 0);

        // timeout on byte 3
        withhold_idx = 3;
        b0 = cap_bytes.size(); to0 = obs_to;
        send_rx(CMD_RD);
        wait_end(600, 0);
        withhold_idx = -1;
        check("t5_timeouts", obs_to - to0, 1);
        check("t5_nbytes", cap_bytes.size() - b0, 4);
        if (cap_bytes.size() >= b0 + 4) check("t5_timeout_delay", last_to_cyc - cap_cyc[b0+3], TMO);
        check("t5_busy_at_timeout", busy_at_to, 0);
        repeat (2) tick();
        b0 = cap_bytes.size();
        send_rx(CMD_RD);
        wait_end(400, 0);
        check("t5_retry_nbytes", cap_bytes.size() - b0, FLEN);
        if (cap_bytes.size() > b0) check("t5_retry_hdr", cap_bytes[b0], 8'h06);
        repeat (3) tick();

        // reset in WAIT at byte 10
        b0 = cap_bytes.size(); fd0 = obs_fd;
        send_rx(CMD_RD);
        wait_bytes(b0 + 11, 300);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy",     sif.busy,        0);
        check("t6_rst_tx_start", sif.tx_start,    0);
        check("t6_rst_tx_data",  sif.tx_data,     0);
        check("t6_rst_fd",       sif.frame_done,  0);
        check("t6_rst_to",       sif.timeout_err, 0);
        check("t6_rst_clr",      sif.clr_req,     0);
        repeat (20) tick();
        check("t6_no_frame_done", obs_fd - fd0, 0);
        b0 = cap_bytes.size();
        send_rx(CMD_RD);
        wait_end(400, 0);
        check("t6_after_rst_nbytes", cap_bytes.size() - b0, FLEN);
        repeat (3) tick();

        // tx_done on the timeout terminal cycle
        slow_idx = 2; slow_delay = TMO - 1;
        b0 = cap_bytes.size(); fd0 = obs_fd; to0 = obs_to;
        send_rx(CMD_RD);
        wait_end(700, 0);
        slow_idx = -1;
        check("t6_coinc_timeouts", obs_to - to0, 0);
        check("t6_coinc_frames", obs_fd - fd0, 1);
        if (cap_bytes.size() >= b0 + 4) check("t6_coinc_gap", cap_cyc[b0+3] - cap_cyc[b0+2], TMO);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
